// File: rtl/play_judge_pkg.sv
// Shared constants for the note-judging stage: lane count, vga_bottom field offsets,
// FSM encodings, saturation limits and a saturating-add helper.
package play_judge_pkg;

   localparam int NUM_LANES = 7;

   localparam int NOTE_LSB  = 2;
   localparam int NOTE_MSB  = 8;
   localparam int SHIFT_LSB = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int SCORE_MAX = 9999;
   localparam int CNT_MAX   = 999;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] lim);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, lim}) ? lim : sum[15:0];
   endfunction

endpackage

// File: rtl/play_judge_if.sv
// Bundle between the note display / key front end (master) and the judge (slave).
interface play_judge_if;
   import play_judge_pkg::*;

   logic [9:0]           vga_bottom;
   logic [NUM_LANES-1:0] key;
   logic [1:0]           key_shift;
   logic                 start;
   logic                 song_done;
   logic [1:0]           state;
   logic                 hit_pulse;
   logic                 miss_pulse;
   logic [13:0]          score;
   logic [9:0]           combo;
   logic [9:0]           max_combo;
   logic [9:0]           hit_count;
   logic [9:0]           miss_count;

   modport master (
      output vga_bottom, key, key_shift, start, song_done,
      input  state, hit_pulse, miss_pulse, score, combo, max_combo, hit_count, miss_count
   );

   modport slave (
      input  vga_bottom, key, key_shift, start, song_done,
      output state, hit_pulse, miss_pulse, score, combo, max_combo, hit_count, miss_count
   );

endinterface

// File: rtl/play_judge_lane_judge.sv
// One lane's hit window: opens on note arrival, counts down, and emits a
// combinational one-cycle hit or miss when a press or expiry closes it.
module lane_judge #(
   parameter int WINDOW = 2_500_000,
   parameter int WIN_W  = 22
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic arrival,
   input  logic press,
   input  logic shift_ok,
   output logic hit,
   output logic miss
);

   logic [WIN_W-1:0] cnt_r;
   logic [WIN_W-1:0] cnt_nx;
   logic             open;

   assign open = (cnt_r != '0);

   always_comb begin
      hit    = 1'b0;
      miss   = 1'b0;
      cnt_nx = cnt_r;
      if (!enable) begin
         cnt_nx = '0;
      end else if (arrival) begin
         // A note still pending when the next one lands is lost.
         miss = open;
         if (press) begin
            hit    = shift_ok;
            miss   = open | ~shift_ok;
            cnt_nx = '0;
         end else begin
            cnt_nx = WIN_W'(WINDOW);
         end
      end else if (open) begin
         if (press) begin
            hit    = shift_ok;
            miss   = ~shift_ok;
            cnt_nx = '0;
         end else begin
            miss   = (cnt_r == WIN_W'(1));
            cnt_nx = cnt_r - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_r <= '0;
      else     cnt_r <= cnt_nx;
   end

endmodule

// File: rtl/play_judge.sv
// Scoring stage: per-lane hit/miss judging, FSM and saturating statistics.
// Events appear on the pulse/counter outputs one cycle after the judging cycle.
module play_judge
   import play_judge_pkg::*;
#(
   parameter int WINDOW     = 2_500_000,
   parameter int WIN_W      = 22,
   parameter int HIT_POINTS = 10
) (
   input  logic vga_clk,
   input  logic rst,
   play_judge_if.slave bus
);

   logic [1:0]           state_r;
   logic [NUM_LANES-1:0] note_q, key_q, note_now;
   logic [NUM_LANES-1:0] arrival, press, hits, misses;
   logic                 shift_ok, enable;
   logic [2:0]           h, m;
   logic                 hit_pulse_r, miss_pulse_r;
   logic [13:0]          score_r, score_nx;
   logic [9:0]           combo_r, combo_nx, max_combo_r, max_nx;
   logic [9:0]           hit_count_r, hit_nx, miss_count_r, miss_nx;
   logic                 unused_bit9;

   assign unused_bit9 = bus.vga_bottom[9];
   assign note_now    = bus.vga_bottom[NOTE_MSB:NOTE_LSB];
   assign arrival     = note_now & ~note_q;
   assign press       = bus.key & ~key_q;
   assign shift_ok    = (bus.key_shift == bus.vga_bottom[SHIFT_LSB+1:SHIFT_LSB]);
   // Lanes are held cleared while not playing and on the cycle PLAY is (re)entered.
   assign enable      = (state_r == ST_PLAY) && !bus.start && !bus.song_done;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_judge #(.WINDOW(WINDOW), .WIN_W(WIN_W)) u_lane (
         .clk      (vga_clk),
         .rst      (rst),
         .enable   (enable),
         .arrival  (arrival[i]),
         .press    (press[i]),
         .shift_ok (shift_ok),
         .hit      (hits[i]),
         .miss     (misses[i])
      );
   end

   assign h = 3'($countones(hits));
   assign m = 3'($countones(misses));

   assign score_nx = 14'(sat_add(16'(score_r), 16'(h * HIT_POINTS), 16'(SCORE_MAX)));
   assign hit_nx   = 10'(sat_add(16'(hit_count_r), 16'(h), 16'(CNT_MAX)));
   assign miss_nx  = 10'(sat_add(16'(miss_count_r), 16'(m), 16'(CNT_MAX)));
   assign combo_nx = (m != 3'd0) ? 10'(h)
                                 : 10'(sat_add(16'(combo_r), 16'(h), 16'(CNT_MAX)));
   assign max_nx   = (combo_nx > max_combo_r) ? combo_nx : max_combo_r;

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         note_q       <= '0;
         key_q        <= '0;
         hit_pulse_r  <= 1'b0;
         miss_pulse_r <= 1'b0;
         score_r      <= '0;
         combo_r      <= '0;
         max_combo_r  <= '0;
         hit_count_r  <= '0;
         miss_count_r <= '0;
      end else begin
         note_q <= note_now;
         key_q  <= bus.key;
         if (bus.start) begin
            state_r      <= ST_PLAY;
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            score_r      <= '0;
            combo_r      <= '0;
            max_combo_r  <= '0;
            hit_count_r  <= '0;
            miss_count_r <= '0;
         end else begin
            if (bus.song_done && state_r == ST_PLAY) state_r <= ST_DONE;
            hit_pulse_r  <= (h != 3'd0);
            miss_pulse_r <= (m != 3'd0);
            score_r      <= score_nx;
            combo_r      <= combo_nx;
            max_combo_r  <= max_nx;
            hit_count_r  <= hit_nx;
            miss_count_r <= miss_nx;
         end
      end
   end

   assign bus.state      = state_r;
   assign bus.hit_pulse  = hit_pulse_r;
   assign bus.miss_pulse = miss_pulse_r;
   assign bus.score      = score_r;
   assign bus.combo      = combo_r;
   assign bus.max_combo  = max_combo_r;
   assign bus.hit_count  = hit_count_r;
   assign bus.miss_count = miss_count_r;

endmodule

// File: tb/tb_play_judge.sv
// Directed bench for play_judge with a short hit window.
module tb_play_judge;
   import play_judge_pkg::*;

   logic vga_clk = 1'b0;
   logic rst     = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 vga_clk = ~vga_clk;

   play_judge_if bus ();

   play_judge #(.WINDOW(8), .WIN_W(4), .HIT_POINTS(10)) dut (
      .vga_clk (vga_clk),
      .rst     (rst),
      .bus     (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge vga_clk);
         #1;
      end
   endtask

   task automatic note(input int lane, input logic v);
      bus.vga_bottom[NOTE_LSB + lane] = v;
   endtask

   // Arrival, press one cycle later with matching shift, then release.
   task automatic hit_lane(input int lane);
      note(lane, 1'b1);
      cyc();
      bus.key[lane] = 1'b1;
      cyc();
      note(lane, 1'b0);
      bus.key[lane] = 1'b0;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.vga_bottom = '0;
      bus.key        = '0;
      bus.key_shift  = 2'd0;
      bus.start      = 1'b0;
      bus.song_done  = 1'b0;
      cyc(2);
      rst = 1'b0;

      check("rst_state", 32'(bus.state), 32'(ST_IDLE));
      check("rst_score", 32'(bus.score), 0);
      check("rst_counts", 32'({bus.hit_count, bus.miss_count, bus.combo}), 0);
      check("rst_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 0);

      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("start_state", 32'(bus.state), 32'(ST_PLAY));

      // Lane 0: arrival at t, press at t+3 -> hit visible at t+4.
      note(0, 1'b1);
      cyc(3);
      check("t1_no_early_hit", 32'(bus.hit_pulse), 0);
      bus.key[0] = 1'b1;
      cyc();
      check("t1_hit_pulse", 32'(bus.hit_pulse), 1);
      check("t1_score", 32'(bus.score), 10);
      check("t1_combo", 32'(bus.combo), 1);
      check("t1_hit_count", 32'(bus.hit_count), 1);
      bus.key[0] = 1'b0;
      note(0, 1'b0);
      cyc();
      check("t1_pulse_clear", 32'(bus.hit_pulse), 0);

      // Lane 2: no press, miss 9 cycles after arrival.
      note(2, 1'b1);
      cyc(8);
      check("t2_no_early_miss", 32'(bus.miss_pulse), 0);
      cyc();
      check("t2_miss_pulse", 32'(bus.miss_pulse), 1);
      check("t2_combo", 32'(bus.combo), 0);
      check("t2_miss_count", 32'(bus.miss_count), 1);
      check("t2_max_combo", 32'(bus.max_combo), 1);
      bus.key[2] = 1'b1;
      cyc();
      check("t2_late_press", 32'({bus.hit_pulse, bus.miss_pulse}), 0);
      check("t2_late_counts", 32'({bus.hit_count, bus.miss_count}), 32'({10'd1, 10'd1}));
      bus.key[2] = 1'b0;
      note(2, 1'b0);
      cyc();

      // Three hits, then lane 1 hit at lane 4's expiry in the same cycle.
      hit_lane(0);
      hit_lane(3);
      hit_lane(6);
      check("t3_combo3", 32'(bus.combo), 3);
      check("t3_score40", 32'(bus.score), 40);
      note(1, 1'b1);
      note(4, 1'b1);
      cyc(8);
      bus.key[1] = 1'b1;
      cyc();
      check("t3_both_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'(2'b11));
      check("t3_combo", 32'(bus.combo), 1);
      check("t3_max_combo", 32'(bus.max_combo), 3);
      check("t3_counts", 32'({bus.hit_count, bus.miss_count}), 32'({10'd5, 10'd2}));
      cyc();
      check("t3_pulses_clear", 32'({bus.hit_pulse, bus.miss_pulse}), 0);
      bus.key[1] = 1'b0;
      note(1, 1'b0);
      note(4, 1'b0);
      cyc();

      // Lane 5 press with wrong octave shift.
      note(5, 1'b1);
      cyc();
      bus.key_shift = 2'd1;
      bus.key[5]    = 1'b1;
      cyc();
      check("t4_shift_miss", 32'({bus.hit_pulse, bus.miss_pulse}), 32'(2'b01));
      check("t4_miss_count", 32'(bus.miss_count), 3);
      check("t4_combo", 32'(bus.combo), 0);
      bus.key[5] = 1'b0;
      cyc();
      bus.key[5] = 1'b1;
      cyc();
      check("t4_second_press", 32'({bus.hit_pulse, bus.miss_pulse}), 0);
      cyc(10);
      check("t4_no_expiry", 32'({bus.hit_count, bus.miss_count}), 32'({10'd5, 10'd3}));
      bus.key       = '0;
      bus.key_shift = 2'd0;
      note(5, 1'b0);
      cyc();

      // Score saturation with two hits in one cycle.
      dut.score_r = 14'd9995;
      note(0, 1'b1);
      note(6, 1'b1);
      cyc();
      bus.key[0] = 1'b1;
      bus.key[6] = 1'b1;
      cyc();
      check("t5_score_sat", 32'(bus.score), 9999);
      check("t5_hit_count", 32'(bus.hit_count), 7);
      check("t5_combo", 32'(bus.combo), 2);
      bus.key = '0;
      note(0, 1'b0);
      note(6, 1'b0);
      cyc();

      // song_done with lane 3 open, then restart.
      note(3, 1'b1);
      cyc(2);
      bus.song_done = 1'b1;
      cyc();
      bus.song_done = 1'b0;
      check("t6_done_state", 32'(bus.state), 32'(ST_DONE));
      cyc(10);
      check("t6_no_discard_miss", 32'(bus.miss_count), 3);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("t6_replay_state", 32'(bus.state), 32'(ST_PLAY));
      check("t6_stats_clear", 32'({bus.score, bus.combo, bus.max_combo}), 0);
      check("t6_counts_clear", 32'({bus.hit_count, bus.miss_count}), 0);
      cyc(12);
      check("t6_window_gone", 32'(bus.miss_count), 0);
      note(3, 1'b0);
      cyc();

      // Reset mid-song.
      hit_lane(2);
      check("t7_pre_rst_hits", 32'(bus.hit_count), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("t7_rst_state", 32'(bus.state), 32'(ST_IDLE));
      check("t7_rst_stats", 32'({bus.score, bus.hit_count}), 0);

      // start and song_done together: start wins.
      bus.start     = 1'b1;
      bus.song_done = 1'b1;
      cyc();
      bus.start     = 1'b0;
      bus.song_done = 1'b0;
      check("t8_start_wins", 32'(bus.state), 32'(ST_PLAY));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/play_judge.md
Name: play_judge

Overview:
Scoring stage directly downstream of the play-mode note display. It consumes the packed bottom-row vector (`vga_bottom`) and judges the player's debounced key presses against notes reaching the hit line, one lane per note C..B. It produces hit/miss events, score, combo and counters for the score overlay and the seven-segment driver.

Parameters:
NUM_LANES, 7, number of note lanes (C,D,E,F,G,A,B = lanes 0..6)
WINDOW, 2_500_000, hit window length in vga_clk cycles after a note reaches the bottom row
WIN_W, 22, width of the per-lane window counter; must satisfy WINDOW < 2^WIN_W
HIT_POINTS, 10, score added per hit
SCORE_MAX, 9999, score saturation value (4-digit BCD display)
CNT_MAX, 999, saturation value for combo, max_combo, hit_count and miss_count

Ports:
vga_clk  in  1  single clock for the block
rst  in  1  synchronous reset, active-high
vga_bottom  in  10  bit9 unused; bits8:2 = bottom-row occupancy of lanes 6..0; bits1:0 = required shift
key  in  7  debounced lane keys, level, bit i = lane i
key_shift  in  2  player's current octave shift
start  in  1  one-cycle pulse: clear statistics and begin judging
song_done  in  1  one-cycle pulse: stop judging
state  out  2  0=IDLE, 1=PLAY, 2=DONE
hit_pulse  out  1  one-cycle pulse on any hit
miss_pulse  out  1  one-cycle pulse on any miss
score  out  14  accumulated score
combo  out  10  current consecutive hits
max_combo  out  10  best combo this song
hit_count  out  10  total hits
miss_count  out  10  total misses

Behaviour:
- Reset: state=IDLE; all counters, pulses, window counters and edge registers are 0.
- FSM transitions:
  - IDLE -start-> PLAY.
  - PLAY -song_done-> DONE.
  - DONE -start-> PLAY.
  - If start and song_done arrive in the same cycle, start wins.
  - Entering PLAY clears score, combo, max_combo, counts and all lane windows in that same cycle.
  - In IDLE and DONE, no events are generated and outputs hold.
- Edge detection: vga_bottom lane bits and key are each registered once.
  - Note arrival = 0->1 on a lane's bottom bit.
  - Press = 0->1 on key[i].
- Per lane (PLAY only):
  - Arrival opens the window: counter = WINDOW.
  - While the window is open, the counter decrements by 1 per cycle.
  - Press while open and key_shift == vga_bottom[1:0] -> hit; window closes.
  - Press while open with a shift mismatch -> miss; window closes.
  - Counter reaches 0 with no press -> miss in the cycle the counter reaches 0; window closes.
  - Press with no window open -> ignored (no event).
  - Arrival and press in the same cycle -> hit.
  - Press in the same cycle as expiry -> hit.
  - Arrival while the window is still open -> the old note is a miss and the window reloads to WINDOW.
- Aggregation, registered with 1-cycle latency from the event cycle:
  - h = popcount(hits), m = popcount(misses); h and m are each in 0..7.
  - hit_count += h, miss_count += m, both saturating at CNT_MAX.
  - score += h*HIT_POINTS, saturating at SCORE_MAX and never wrapping.
  - If m > 0: combo = h, so hits in the same cycle start a new combo. Otherwise combo += h, saturating at CNT_MAX.
  - max_combo = max(max_combo, new combo).
  - hit_pulse = (h > 0) and miss_pulse = (m > 0); both may be high together.
- Reset mid-song: immediate return to IDLE with everything cleared. No pending miss is reported.
- song_done with windows open: windows are discarded without a miss.

Decomposition:
- Shared package holds:
  - NUM_LANES.
  - Field offsets of vga_bottom: NOTE_LSB=2, NOTE_MSB=8, SHIFT_LSB=0.
  - FSM state encodings IDLE/PLAY/DONE.
  - SCORE_MAX and CNT_MAX.
- Sub-module lane_judge is instantiated NUM_LANES times.
  - Inputs: arrival, press, shift_ok, enable.
  - Contains the window counter.
  - Outputs: one-cycle hit and miss.
- The top level holds the FSM, popcounts and saturating accumulators.

Test Plan:
- WINDOW=8, start; lane 0 arrival at t, key[0] rise at t+3 with shift match -> hit_pulse at t+4, score=10, combo=1, hit_count=1.
- Lane 2 arrival with no press -> miss_pulse exactly 9 cycles after arrival (counter hits 0 at arrival+8, result registered next cycle), combo=0, miss_count=1; a key[2] press afterwards produces nothing.
- Three hits, then lanes 1 and 4 arrive together; lane 1 is hit, lane 4 misses in the same cycle -> combo=1 (from 3), max_combo=3, both pulses high for one cycle.
- Press key[5] with key_shift=1 while vga_bottom[1:0]=0 -> miss, window closed; a second press in the same window is ignored.
- Force the score to 9995 and hit two lanes in one cycle -> score=9999, hit_count +2.
- song_done with lane 3 window open, then start -> state DONE then PLAY, no miss reported, all statistics 0; assert rst mid-PLAY -> state=IDLE next cycle.
